// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_driver
// Description : Clocked command front-end for a cross-coupled NAND SR latch.
//               Issues fixed-width active-low set/reset pulses, waits for the
//               latch to settle, then verifies its synchronized outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_driver #(
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_op,
  output logic s_n,
  output logic r_n,
  input  logic q_in,
  input  logic q_bar_in,
  output logic done,
  output logic err,
  output logic state_q
);

  localparam int         c_SYNC_DEPTH = 2;
  localparam logic [7:0] c_PULSE_LD   = 8'(PULSE_CYC - 1);
  localparam logic [7:0] c_SETTLE_LD  = 8'(SETTLE_CYC - 1);

  if ((PULSE_CYC < 1) || (PULSE_CYC > 255)) begin : g_bad_pulse
    $error("sr_latch_driver: PULSE_CYC=%0d outside 1..255", PULSE_CYC);
  end

  if ((SETTLE_CYC < c_SYNC_DEPTH) || (SETTLE_CYC > 255)) begin : g_bad_settle
    $error("sr_latch_driver: SETTLE_CYC=%0d outside %0d..255", SETTLE_CYC, c_SYNC_DEPTH);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_op;
  logic       w_op_nxt;
  logic       w_pass;

  logic       r_q_meta;
  logic       r_q_sync;
  logic       r_qb_meta;
  logic       r_qb_sync;

  logic       r_s_n;
  logic       r_r_n;
  logic       r_done;
  logic       r_err;
  logic       r_state_q;

  assign cmd_ready = (r_state == IDLE) && rst_n;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_op_nxt    = cmd_op;
          w_cnt_nxt   = c_PULSE_LD;
          w_state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (r_cnt == 8'd0) begin
          w_cnt_nxt   = c_SETTLE_LD;
          w_state_nxt = SETTLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = CHECK;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Readback is judged on the cycle before CHECK so done/err can be registered.
  assign w_pass = (r_q_sync == r_op) && (r_qb_sync == ~r_op);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_op      <= 1'b0;
      r_q_meta  <= 1'b0;
      r_q_sync  <= 1'b0;
      r_qb_meta <= 1'b0;
      r_qb_sync <= 1'b0;
      r_s_n     <= 1'b1;
      r_r_n     <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_state_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_q_meta  <= q_in;
      r_q_sync  <= r_q_meta;
      r_qb_meta <= q_bar_in;
      r_qb_sync <= r_qb_meta;
      // Each strobe depends on one polarity of the same op bit, so both low is impossible.
      r_s_n     <= ~((w_state_nxt == PULSE) && w_op_nxt);
      r_r_n     <= ~((w_state_nxt == PULSE) && ~w_op_nxt);
      r_done    <= (w_state_nxt == CHECK);
      r_err     <= (w_state_nxt == CHECK) && ~w_pass;
      if (r_done && !r_err) begin
        r_state_q <= r_op;
      end
    end
  end

  assign s_n     = r_s_n;
  assign r_n     = r_r_n;
  assign done    = r_done;
  assign err     = r_err;
  assign state_q = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_latch_driver
// Description : Self-checking bench; channel 0 uses default timing, channel 1
//               uses PULSE_CYC=1/SETTLE_CYC=2, each driving a NAND latch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;

  localparam int P0 = 4;
  localparam int S0 = 2;
  localparam int P1 = 1;
  localparam int S1 = 2;
  localparam int DC = -1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd_valid;
  logic [1:0] cmd_op;
  logic [1:0] fault;
  logic [1:0] cmd_ready;
  logic [1:0] s_n;
  logic [1:0] r_n;
  logic [1:0] done;
  logic [1:0] err;
  logic [1:0] state_q;
  logic [1:0] q_in;
  logic [1:0] q_bar_in;
  logic [1:0] lq = 2'b00;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;

  logic       mvalid = 1'b0;
  logic [1:0] busy   = 2'b00;
  logic [1:0] mop    = 2'b00;
  logic [1:0] sq     = 2'b00;
  int         acc [2];

  int         lit_ch   = 0;
  logic [5:0] lit_mask = '0;
  logic [5:0] lit_val  = '0;
  string      lit_nm [6] = '{"s_n", "r_n", "done", "err", "state_q", "cmd_ready"};

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    sr_latch_driver #(
      .PULSE_CYC (i == 0 ? P0 : P1),
      .SETTLE_CYC(i == 0 ? S0 : S1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cmd_valid[i]),
      .cmd_ready(cmd_ready[i]),
      .cmd_op   (cmd_op[i]),
      .s_n      (s_n[i]),
      .r_n      (r_n[i]),
      .q_in     (q_in[i]),
      .q_bar_in (q_bar_in[i]),
      .done     (done[i]),
      .err      (err[i]),
      .state_q  (state_q[i])
    );

    a_sr_legal: assert property (@(posedge clk) disable iff (!mvalid) (s_n[i] | r_n[i]))
      else $error("FAIL invariant ch%0d: s_n and r_n both low", i);
    a_err_done: assert property (@(posedge clk) disable iff (!mvalid) (!err[i] || done[i]))
      else $error("FAIL invariant ch%0d: err without done", i);
  end

  // NAND latch: a low set forces q=1, a low reset forces q=0, otherwise it holds.
  always @(s_n or r_n) begin
    for (int c = 0; c < 2; c++) begin
      if (s_n[c] == 1'b0)      lq[c] = 1'b1;
      else if (r_n[c] == 1'b0) lq[c] = 1'b0;
    end
  end

  assign q_in     = lq & ~fault;
  assign q_bar_in = ~lq & ~fault;

  function automatic int pw(input int c);
    return (c == 0) ? P0 : P1;
  endfunction

  function automatic int sw(input int c);
    return (c == 0) ? S0 : S1;
  endfunction

  function automatic logic mism(input int c);
    return !((q_in[c] == mop[c]) && (q_bar_in[c] == !mop[c]));
  endfunction

  // Transaction-level model: remembers the acceptance cycle and derives every
  // output window from it by offset arithmetic.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        mvalid  <= 1'b1;
        busy[c] <= 1'b0;
        sq[c]   <= 1'b0;
      end else if (!busy[c]) begin
        if (cmd_valid[c]) begin
          busy[c] <= 1'b1;
          acc[c]  <= cyc;
          mop[c]  <= cmd_op[c];
        end
      end else if (cyc - acc[c] == pw(c) + sw(c) + 1) begin
        busy[c] <= 1'b0;
        if (!mism(c)) sq[c] <= mop[c];
      end
    end
  end

  task automatic chk(input string nm, input int c, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d cycle %0d: got %b expected %b", nm, c, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      for (int c = 0; c < 2; c++) begin
        int   k;
        logic pl;
        logic e_done;
        k      = cyc - acc[c];
        pl     = busy[c] && (k >= 1) && (k <= pw(c));
        e_done = busy[c] && (k == pw(c) + sw(c) + 1);
        chk("s_n", c, s_n[c], !(pl && mop[c]));
        chk("r_n", c, r_n[c], !(pl && !mop[c]));
        chk("done", c, done[c], e_done);
        chk("err", c, err[c], e_done && mism(c));
        chk("state_q", c, state_q[c], sq[c]);
        chk("cmd_ready", c, cmd_ready[c], rst_n && !busy[c]);
        chk("never_both_low", c, s_n[c] | r_n[c], 1'b1);
      end
    end
    for (int b = 0; b < 6; b++) begin
      if (lit_mask[b]) begin
        logic [5:0] act;
        act = {cmd_ready[lit_ch], state_q[lit_ch], err[lit_ch],
               done[lit_ch], r_n[lit_ch], s_n[lit_ch]};
        chk({"lit_", lit_nm[b]}, lit_ch, act[b], lit_val[b]);
      end
    end
  end

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      lit_mask = '0;
    end
  endtask

  task automatic lit(input int c, input int sn, input int rn, input int dn,
                     input int er, input int sqv, input int rdy);
    int v [6];
    v      = '{sn, rn, dn, er, sqv, rdy};
    lit_ch = c;
    for (int b = 0; b < 6; b++) begin
      lit_mask[b] = (v[b] >= 0);
      lit_val[b]  = (v[b] == 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 2'b00;
    cmd_op    = 2'b00;
    fault     = 2'b00;
    tk(3);
    rst_n = 1'b1;
    lit(0, 1, 1, 0, 0, 0, 1);

    // Set on channel 0; op toggles during the pulse must be ignored.
    cmd_op[0] = 1'b1; cmd_valid[0] = 1'b1;
    tk(1); cmd_valid[0] = 1'b0; cmd_op[0] = 1'b0;
    lit(0, 0, 1, DC, DC, DC, 0);
    tk(3); lit(0, 0, 1, 0, DC, DC, 0);
    tk(1); lit(0, 1, 1, DC, DC, DC, DC);
    tk(2); lit(0, 1, 1, 1, 0, 0, 0);
    tk(1); lit(0, DC, DC, 0, 0, 1, 1);

    // Reset the latch.
    cmd_op[0] = 1'b0; cmd_valid[0] = 1'b1;
    tk(1); cmd_valid[0] = 1'b0;
    lit(0, 1, 0, DC, DC, 1, 0);
    tk(3); lit(0, 1, 0, DC, DC, DC, DC);
    tk(3); lit(0, 1, 1, 1, 0, DC, DC);
    tk(1); lit(0, DC, DC, 0, DC, 0, 1);

    // Both readbacks stuck low: a set must report err and leave state_q alone.
    fault[0] = 1'b1;
    tk(2);
    cmd_op[0] = 1'b1; cmd_valid[0] = 1'b1;
    tk(1); cmd_valid[0] = 1'b0;
    lit(0, 0, 1, DC, DC, DC, DC);
    tk(6); lit(0, 1, 1, 1, 1, 0, 0);
    tk(1); lit(0, DC, DC, 0, 0, 0, 1);

    // Reset asserted in cycle 2 of a set pulse.
    fault[0] = 1'b0;
    cmd_op[0] = 1'b1; cmd_valid[0] = 1'b1;
    tk(1); cmd_valid[0] = 1'b0;
    tk(1); rst_n = 1'b0;
    tk(1); rst_n = 1'b1;
    lit(0, 1, 1, 0, 0, 0, 1);
    tk(4); lit(0, 1, 1, 0, DC, 0, 1);

    // Back-to-back on channel 1 with valid held high: ops 1, 0, 1.
    cmd_op[1] = 1'b1; cmd_valid[1] = 1'b1;
    tk(1); lit(1, 0, 1, DC, DC, DC, 0);
    cmd_op[1] = 1'b0;
    tk(3); lit(1, 1, 1, 1, 0, DC, 0);
    tk(1); lit(1, DC, DC, 0, DC, 1, 1);
    tk(1); lit(1, 1, 0, DC, DC, DC, 0);
    cmd_op[1] = 1'b1;
    tk(3); lit(1, DC, DC, 1, 0, DC, 0);
    tk(1); lit(1, DC, DC, 0, DC, 0, 1);
    tk(1); lit(1, 0, 1, DC, DC, DC, 0);
    cmd_valid[1] = 1'b0;
    tk(3); lit(1, DC, DC, 1, 0, DC, DC);
    tk(1); lit(1, DC, DC, 0, DC, 1, 1);
    tk(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
